// File: rtl/axis_pack_arb_pkg.sv
// Shared types and constants for the packet round-robin arbiter that feeds the nibble packer.
package axis_pack_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    // tkeep carries a valid-bit count, not a byte mask
    localparam logic [7:0] KEEP_4  = 8'd4;
    localparam logic [7:0] KEEP_8  = 8'd8;
    localparam logic [7:0] KEEP_12 = 8'd12;
    localparam logic [7:0] KEEP_16 = 8'd16;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic keep_legal(input logic [7:0] k);
        return (k == KEEP_4) || (k == KEEP_8) || (k == KEEP_12) || (k == KEEP_16);
    endfunction

endpackage

// File: rtl/axis_pack_arb_if.sv
// AXI-Stream bundle carrying LANES parallel streams; one instance for the sources, one for the packer.
interface axis_pack_arb_if #(
    parameter int LANES      = 1,
    parameter int DATA_WIDTH = 16
);
    logic [LANES*DATA_WIDTH-1:0] tdata;
    logic [LANES-1:0]            tvalid;
    logic [LANES-1:0]            tready;
    logic [LANES-1:0]            tlast;
    logic [LANES*8-1:0]          tkeep;

    modport master (output tdata, output tvalid, output tlast, output tkeep, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tkeep, output tready);
endinterface

// File: rtl/axis_pack_arb_rr_pick.sv
// Combinational cyclic-priority pick: first requester at or after rr_ptr, wrapping around.
module axis_pack_arb_rr_pick
    import axis_pack_arb_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    localparam int SEL_W   = sel_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   rr_ptr,
    output logic [SEL_W-1:0]   winner,
    output logic               any_req
);

    int               idx;
    logic [SEL_W-1:0] idx_s;

    // Walk offsets from farthest to nearest so the nearest requester is the last write.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        idx_s   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            idx_s = SEL_W'(idx);
            if (req[idx_s]) begin
                winner  = idx_s;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_pack_arbiter.sv
// Packet-locked round-robin arbiter in front of the nibble packer, with a post-tlast flush gap.
// Optional macro AXIS_PACK_ARB_KEEP_CHECK_EN: flag illegal tkeep and force it to 16 on that beat.
module axis_pack_arbiter
    import axis_pack_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_SRC    = 4,
    parameter  int GAP_CYCLES = 2,
    localparam int SEL_W      = sel_w(NUM_SRC)
) (
    input  logic             clk,
    input  logic             areset,
    axis_pack_arb_if.slave   s_axis,
    axis_pack_arb_if.master  m_axis,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_idx,
    output logic             keep_err
);

    arb_state_e       state;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant_q;
    logic [3:0]       gap_cnt;

    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] rr_next;
    logic             any_req;

    logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0][7:0]            src_keep;
    logic [NUM_SRC-1:0]                 rdy;

    logic                  active;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [7:0]            sel_keep;
    logic [7:0]            keep_out;
    logic                  m_valid;
    logic                  hs;

    assign src_data = s_axis.tdata;
    assign src_keep = s_axis.tkeep;

    axis_pack_arb_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req     (s_axis.tvalid),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign rr_next = (winner == SEL_W'(NUM_SRC - 1)) ? '0 : winner + SEL_W'(1);

    // Outputs are gated by areset so nothing leaks during the reset cycle itself.
    assign active    = (state == BURST) && !areset;
    assign sel_valid = s_axis.tvalid[grant_q];
    assign sel_last  = s_axis.tlast[grant_q];
    assign sel_data  = src_data[grant_q];
    assign sel_keep  = src_keep[grant_q];
    assign m_valid   = active && sel_valid;
    assign hs        = m_valid && m_axis.tready;

`ifdef AXIS_PACK_ARB_KEEP_CHECK_EN
    logic keep_bad;
    logic keep_err_q;

    assign keep_bad = !keep_legal(sel_keep);
    assign keep_out = keep_bad ? KEEP_16 : sel_keep;
    assign keep_err = keep_err_q && !areset;

    always_ff @(posedge clk) begin
        if (areset)              keep_err_q <= 1'b0;
        else if (hs && keep_bad) keep_err_q <= 1'b1;
    end
`else
    assign keep_out = sel_keep;
    assign keep_err = 1'b0;
`endif

    // Idle bus reads as zeros so the packer never sees a stale mux value.
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = m_valid ? sel_data : '0;
    assign m_axis.tlast  = m_valid && sel_last;
    assign m_axis.tkeep  = m_valid ? keep_out : '0;

    always_comb begin
        rdy = '0;
        if (active) rdy[grant_q] = m_axis.tready;
    end
    assign s_axis.tready = rdy;

    assign grant_valid = active;
    assign grant_idx   = areset ? '0 : grant_q;

    always_ff @(posedge clk) begin
        if (areset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gap_cnt <= '0;
            grant_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= winner;
                        rr_ptr  <= rr_next;
                        state   <= BURST;
                    end
                end
                BURST: begin
                    // Grant stays locked through source bubbles; only the tlast handshake releases it.
                    if (hs && sel_last) begin
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= 4'(GAP_CYCLES - 1);
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) state <= IDLE;
                    else                 gap_cnt <= gap_cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pack_arbiter.sv
// Self-checking bench: directed scenarios plus randomized packets against a packet-level round-robin model.
module tb_axis_pack_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [7:0]    k;
        logic          l;
    } beat_t;

    logic       clk = 1'b0;
    logic       areset;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       keep_err;

    always #5 clk = ~clk;

    axis_pack_arb_if #(.LANES(N), .DATA_WIDTH(DW)) s_bus ();
    axis_pack_arb_if #(.LANES(1), .DATA_WIDTH(DW)) m_bus ();

    axis_pack_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(N), .GAP_CYCLES(2)) dut (
        .clk         (clk),
        .areset      (areset),
        .s_axis      (s_bus),
        .m_axis      (m_bus),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .keep_err    (keep_err)
    );

    int nrun  = 0;
    int nfail = 0;

    beat_t pk[N][32];
    int    nb[N];
    int    np[N];
    int    plen[N][8];
    beat_t expq[$];
    int    exp_g[$];
    int    got_g[$];

`ifdef AXIS_PACK_ARB_KEEP_CHECK_EN
    localparam bit KCHK = 1'b1;
`else
    localparam bit KCHK = 1'b0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [DW-1:0] d,
                           input logic [7:0] k, input logic l);
        s_bus.tvalid[i]           = v;
        s_bus.tdata[i*DW +: DW]   = d;
        s_bus.tkeep[i*8 +: 8]     = k;
        s_bus.tlast[i]            = l;
    endtask

    task automatic clear_srcs();
        s_bus.tvalid = '0;
        s_bus.tdata  = '0;
        s_bus.tkeep  = '0;
        s_bus.tlast  = '0;
    endtask

    task automatic reset_dut();
        clear_srcs();
        m_bus.tready = 1'b1;
        areset = 1'b1;
        step();
        step();
        areset = 1'b0;
    endtask

    // Let every still-valid single-beat source finish, bounded.
    task automatic drain();
        logic [N-1:0] hs;
        for (int c = 0; c < 60 && s_bus.tvalid != '0; c++) begin
            m_bus.tready = 1'b1;
            #1;
            hs = s_bus.tvalid & s_bus.tready;
            step();
            for (int i = 0; i < N; i++)
                if (hs[i] && s_bus.tlast[i]) s_bus.tvalid[i] = 1'b0;
        end
        nrun++;
        if (s_bus.tvalid !== '0) begin
            nfail++;
            $display("FAIL drain_timeout: valids still %b, want 0000", s_bus.tvalid);
        end
        repeat (4) step();
    endtask

    task automatic clear_pkts();
        for (int i = 0; i < N; i++) begin
            nb[i] = 0;
            np[i] = 0;
        end
    endtask

    task automatic add_pkt(input int s, input int len, input bit rnd);
        logic [7:0] k;
        for (int b = 0; b < len; b++) begin
            k = rnd ? 8'(4 * $urandom_range(1, 4)) : 8'd16;
            pk[s][nb[s]] = '{d: (rnd ? DW'($urandom) : DW'((s << 8) | (np[s] << 4) | b)),
                             k: k, l: (b == len - 1)};
            nb[s]++;
        end
        plen[s][np[s]] = len;
        np[s]++;
    endtask

    // Reference: whole packets awarded in cyclic order from the source after the last winner.
    task automatic model_build();
        int rem[N];
        int pidx[N];
        int bidx[N];
        int ptr;
        int left;
        int s;
        ptr  = 0;
        left = 0;
        expq.delete();
        exp_g.delete();
        for (int i = 0; i < N; i++) begin
            rem[i] = np[i]; pidx[i] = 0; bidx[i] = 0; left += np[i];
        end
        while (left > 0) begin
            s = -1;
            for (int k = 0; k < N && s < 0; k++)
                if (rem[(ptr + k) % N] > 0) s = (ptr + k) % N;
            exp_g.push_back(s);
            for (int b = 0; b < plen[s][pidx[s]]; b++) begin
                expq.push_back(pk[s][bidx[s]]);
                bidx[s]++;
            end
            pidx[s]++;
            rem[s]--;
            left--;
            ptr = (s + 1) % N;
        end
    endtask

    task automatic run_traffic(input bit rnd_ready);
        int    ptr[N];
        bit    new_pkt;
        int    idle;
        bit    foreign_ok;
        int    cyc;
        beat_t e;
        beat_t got;
        reset_dut();
        model_build();
        got_g.delete();
        for (int i = 0; i < N; i++) ptr[i] = 0;
        new_pkt    = 1'b1;
        idle       = -1;
        foreign_ok = 1'b1;
        cyc        = 0;
        while (expq.size() > 0 && cyc < 3000) begin
            for (int i = 0; i < N; i++) begin
                if (ptr[i] < nb[i]) set_src(i, 1'b1, pk[i][ptr[i]].d, pk[i][ptr[i]].k, pk[i][ptr[i]].l);
                else                set_src(i, 1'b0, '0, '0, 1'b0);
            end
            m_bus.tready = rnd_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
            #1;
            if ((s_bus.tready & ~(grant_valid ? (4'b0001 << grant_idx) : 4'b0000)) != '0)
                foreign_ok = 1'b0;
            if (m_bus.tvalid) begin
                if (idle >= 0) begin
                    nrun++;
                    if (idle !== 3) begin
                        nfail++;
                        $display("FAIL gap_len: %0d idle cycles after tlast, want 3", idle);
                    end
                    idle = -1;
                end
            end else if (idle >= 0) begin
                idle++;
            end
            if (m_bus.tvalid && m_bus.tready) begin
                if (new_pkt) begin
                    got_g.push_back(int'(grant_idx));
                    nrun++;
                    if (exp_g.size() == 0) begin
                        nfail++;
                        $display("FAIL grant_extra: grant %0d, want none", grant_idx);
                    end else if (int'(grant_idx) !== exp_g[0]) begin
                        nfail++;
                        $display("FAIL grant_order: grant %0d, want %0d", grant_idx, exp_g[0]);
                    end
                    if (exp_g.size() > 0) void'(exp_g.pop_front());
                end
                got = '{d: m_bus.tdata, k: m_bus.tkeep, l: m_bus.tlast[0]};
                e   = expq.pop_front();
                nrun++;
                if (got !== e) begin
                    nfail++;
                    $display("FAIL beat: got d=%h k=%0d l=%b, want d=%h k=%0d l=%b",
                             got.d, got.k, got.l, e.d, e.k, e.l);
                end
                for (int i = 0; i < N; i++)
                    if (s_bus.tvalid[i] && s_bus.tready[i]) ptr[i]++;
                new_pkt = m_bus.tlast[0];
                if (m_bus.tlast[0]) idle = 0;
            end
            step();
            cyc++;
        end
        nrun++;
        if (expq.size() != 0) begin
            nfail++;
            $display("FAIL traffic_timeout: %0d beats outstanding, want 0", expq.size());
        end
        nrun++;
        if (!foreign_ok) begin
            nfail++;
            $display("FAIL foreign_ready: ready seen on non-granted source, want none");
        end
        clear_srcs();
        repeat (4) step();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        clear_srcs();
        m_bus.tready = 1'b1;
        step();
        step();
        nrun++;
        if ({grant_valid, m_bus.tvalid, s_bus.tready, keep_err, grant_idx} !== 9'd0) begin
            nfail++;
            $display("FAIL reset_outputs: gv=%b mv=%b rdy=%b ke=%b gi=%0d, want all 0",
                     grant_valid, m_bus.tvalid, s_bus.tready, keep_err, grant_idx);
        end
        areset = 1'b0;
        // src1 3-beat packet, abort after 2 handshakes
        set_src(1, 1'b1, 16'h1110, 8'd16, 1'b0);
        step();
        step();
        set_src(1, 1'b1, 16'h1111, 8'd16, 1'b0);
        step();
        set_src(1, 1'b1, 16'h1112, 8'd16, 1'b1);
        areset = 1'b1;
        step();
        areset = 1'b0;
        clear_srcs();
        #1;
        nrun++;
        if ({grant_valid, m_bus.tvalid, s_bus.tready, keep_err} !== 7'd0) begin
            nfail++;
            $display("FAIL reset_midpkt: gv=%b mv=%b rdy=%b ke=%b, want all 0",
                     grant_valid, m_bus.tvalid, s_bus.tready, keep_err);
        end
        // rr_ptr back at 0: src1 beats src3
        set_src(1, 1'b1, 16'h0001, 8'd4, 1'b1);
        set_src(3, 1'b1, 16'h0003, 8'd4, 1'b1);
        step();
        #1;
        nrun++;
        if (!(grant_valid === 1'b1 && grant_idx === 2'd1)) begin
            nfail++;
            $display("FAIL reset_rrptr: gv=%b grant %0d, want 1/1", grant_valid, grant_idx);
        end
        drain();
    endtask

    task automatic test_round_robin();
        int want[5] = '{0, 1, 2, 3, 0};
        clear_pkts();
        add_pkt(0, 2, 1'b0);
        add_pkt(0, 2, 1'b0);
        for (int s = 1; s < N; s++) add_pkt(s, 2, 1'b0);
        run_traffic(1'b0);
        nrun++;
        if (got_g.size() !== 5) begin
            nfail++;
            $display("FAIL rr_count: %0d grants, want 5", got_g.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                nrun++;
                if (got_g[i] !== want[i]) begin
                    nfail++;
                    $display("FAIL rr_seq[%0d]: grant %0d, want %0d", i, got_g[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            clear_pkts();
            for (int s = 0; s < N; s++)
                for (int p = 0; p < int'($urandom_range(1, 3)); p++)
                    add_pkt(s, $urandom_range(1, 4), 1'b1);
            run_traffic(1'b1);
        end
    endtask

    task automatic test_lock_backpressure();
        int w;
        reset_dut();
        set_src(2, 1'b1, 16'h2200, 8'd16, 1'b0);
        step();
        #1;
        nrun++;
        if (!(grant_valid === 1'b1 && grant_idx === 2'd2)) begin
            nfail++;
            $display("FAIL lock_grant: gv=%b grant %0d, want 1/2", grant_valid, grant_idx);
        end
        set_src(0, 1'b1, 16'h0A0A, 8'd8, 1'b1);
        step();
        set_src(2, 1'b1, 16'h2201, 8'd16, 1'b0);
        m_bus.tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            nrun++;
            if (!(s_bus.tready === 4'b0000 && m_bus.tdata === 16'h2201 && grant_idx === 2'd2)) begin
                nfail++;
                $display("FAIL lock_stall[%0d]: rdy=%b data=%h grant %0d, want 0000/2201/2",
                         c, s_bus.tready, m_bus.tdata, grant_idx);
            end
            step();
        end
        m_bus.tready = 1'b1;
        step();
        set_src(2, 1'b1, 16'h2202, 8'd16, 1'b1);
        step();
        set_src(2, 1'b0, '0, '0, 1'b0);
        w = 0;
        #1;
        while (!grant_valid && w < 10) begin
            step();
            w++;
        end
        nrun++;
        if (!(w === 3 && grant_idx === 2'd0 && m_bus.tdata === 16'h0A0A)) begin
            nfail++;
            $display("FAIL lock_handoff: %0d cycles grant %0d data %h, want 3/0/0a0a",
                     w, grant_idx, m_bus.tdata);
        end
        step();
        set_src(0, 1'b0, '0, '0, 1'b0);
        repeat (4) step();
    endtask

    task automatic test_single_beat();
        reset_dut();
        set_src(3, 1'b1, 16'hABCD, 8'd12, 1'b1);
        #1;
        nrun++;
        if (m_bus.tvalid !== 1'b0) begin
            nfail++;
            $display("FAIL single_latency: mv=%b in request cycle, want 0", m_bus.tvalid);
        end
        step();
        #1;
        nrun++;
        if ({m_bus.tvalid, m_bus.tdata, m_bus.tkeep, m_bus.tlast, grant_idx} !==
            {1'b1, 16'hABCD, 8'd12, 1'b1, 2'd3}) begin
            nfail++;
            $display("FAIL single_beat: v=%b d=%h k=%0d l=%b g=%0d, want 1/abcd/12/1/3",
                     m_bus.tvalid, m_bus.tdata, m_bus.tkeep, m_bus.tlast, grant_idx);
        end
        step();
        set_src(3, 1'b0, '0, '0, 1'b0);
        #1;
        nrun++;
        if ({grant_valid, m_bus.tvalid, m_bus.tdata, m_bus.tkeep, m_bus.tlast} !== 27'd0) begin
            nfail++;
            $display("FAIL single_gap: gv=%b mv=%b d=%h k=%0d l=%b, want all 0",
                     grant_valid, m_bus.tvalid, m_bus.tdata, m_bus.tkeep, m_bus.tlast);
        end
        repeat (4) step();
    endtask

    task automatic test_bubble();
        reset_dut();
        set_src(1, 1'b1, 16'h1100, 8'd16, 1'b0);
        step();
        set_src(0, 1'b1, 16'h0B0B, 8'd16, 1'b1);
        #1;
        nrun++;
        if (!(grant_idx === 2'd1 && m_bus.tvalid === 1'b1)) begin
            nfail++;
            $display("FAIL bubble_grant: grant %0d mv=%b, want 1/1", grant_idx, m_bus.tvalid);
        end
        step();
        set_src(1, 1'b0, '0, '0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            nrun++;
            if (!(m_bus.tvalid === 1'b0 && grant_valid === 1'b1 && grant_idx === 2'd1 &&
                  s_bus.tready[0] === 1'b0)) begin
                nfail++;
                $display("FAIL bubble[%0d]: mv=%b gv=%b grant %0d rdy0=%b, want 0/1/1/0",
                         c, m_bus.tvalid, grant_valid, grant_idx, s_bus.tready[0]);
            end
            step();
        end
        set_src(1, 1'b1, 16'h1101, 8'd16, 1'b1);
        #1;
        nrun++;
        if (!(m_bus.tvalid === 1'b1 && m_bus.tdata === 16'h1101)) begin
            nfail++;
            $display("FAIL bubble_resume: mv=%b data %h, want 1/1101", m_bus.tvalid, m_bus.tdata);
        end
        step();
        set_src(1, 1'b0, '0, '0, 1'b0);
        drain();
    endtask

    task automatic test_keep_check();
        logic [7:0] want_k;
        want_k = KCHK ? 8'd16 : 8'd6;
        reset_dut();
        set_src(0, 1'b1, 16'h0C0C, 8'd6, 1'b1);
        step();
        #1;
        nrun++;
        if (!(m_bus.tkeep === want_k && m_bus.tdata === 16'h0C0C && keep_err === 1'b0)) begin
            nfail++;
            $display("FAIL keep_beat: k=%0d d=%h ke=%b, want %0d/0c0c/0",
                     m_bus.tkeep, m_bus.tdata, keep_err, want_k);
        end
        step();
        set_src(0, 1'b0, '0, '0, 1'b0);
        #1;
        nrun++;
        if (keep_err !== KCHK) begin
            nfail++;
            $display("FAIL keep_err_set: ke=%b, want %b", keep_err, KCHK);
        end
        repeat (5) step();
        nrun++;
        if (keep_err !== KCHK) begin
            nfail++;
            $display("FAIL keep_err_sticky: ke=%b, want %b", keep_err, KCHK);
        end
        reset_dut();
        #1;
        nrun++;
        if (keep_err !== 1'b0) begin
            nfail++;
            $display("FAIL keep_err_reset: ke=%b, want 0", keep_err);
        end
    endtask

    initial begin
        areset = 1'b1;
        clear_srcs();
        m_bus.tready = 1'b0;
        test_reset();
        test_round_robin();
        test_random();
        test_lock_backpressure();
        test_single_beat();
        test_bubble();
        test_keep_check();
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule
